subpel_search_ctrl: RTL and testbench

Sequencer for the horizontal sub-pel SAD datapath (`compute_sad`). For each block, it fetches one 8-pixel row pair at a time from the row buffer. It presents each row pair to the datapath and accumulates the five per-row candidate SADs over the block height. It then selects the best of the five candidates: Right Half, Right Quarter, Full, Left Quarter, Left Half. It sits between the motion-search control FSM and the row buffer, and it owns the datapath's `input_ready`.

---
 rtl/subpel_search_ctrl_pkg.sv | 28 ++
 rtl/subpel_search_ctrl_argmin.sv | 71 +++++++
 rtl/subpel_search_ctrl.sv | 145 ++++++++++++++
 tb/tb_subpel_search_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/subpel_search_ctrl_pkg.sv
// Shared definitions for the sub-pel SAD sequencer: candidate indices,
// per-candidate SAD width, compare priority order and FSM state encoding.
package subpel_search_ctrl_pkg;

    localparam int SAD_W    = 12;
    localparam int NUM_CAND = 5;

    localparam logic [2:0] CAND_RH = 3'd0;
    localparam logic [2:0] CAND_RQ = 3'd1;
    localparam logic [2:0] CAND_F  = 3'd2;
    localparam logic [2:0] CAND_LQ = 3'd3;
    localparam logic [2:0] CAND_LH = 3'd4;

    typedef logic [NUM_CAND-1:0][2:0] cand_order_t;

    // Element 0 is compared first; ties keep the earlier entry.
    localparam cand_order_t CMP_ORDER = {CAND_LH, CAND_RH, CAND_LQ, CAND_RQ, CAND_F};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_ACC,
        ST_CMP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/subpel_search_ctrl_argmin.sv
// sad_argmin5: sequential argmin over five accumulators, one candidate per
// cycle in a caller-supplied order; strictly-smaller replaces the running best.
module sad_argmin5
    import subpel_search_ctrl_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [NUM_CAND-1:0][ACC_W-1:0]   acc,
    input  cand_order_t                      order,
    output logic                             done,
    output logic [2:0]                       best_idx,
    output logic [ACC_W-1:0]                 best_val
);

    logic             running;
    logic [2:0]       step;
    logic [2:0]       run_idx;
    logic [ACC_W-1:0] run_val;

    logic [2:0]       cur_step;
    logic [2:0]       cur_k;
    logic [ACC_W-1:0] cur_val;
    logic             take;

    // The start cycle evaluates the first candidate, so the result of the
    // fifth candidate is available combinationally in the fifth cycle.
    always_comb begin
        cur_step = start ? '0 : step;
        cur_k    = '0;
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            if (cur_step == 3'(i)) cur_k = order[i];
        end
        cur_val = '0;
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            if (cur_k == 3'(i)) cur_val = acc[i];
        end
        take     = (cur_step == '0) || (cur_val < run_val);
        best_idx = take ? cur_k : run_idx;
        best_val = take ? cur_val : run_val;
        done     = (start || running) && (cur_step == 3'(NUM_CAND-1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            step    <= '0;
            run_idx <= '0;
            run_val <= '0;
        end else begin
            if (start) begin
                running <= 1'b1;
                step    <= 3'd1;
            end else if (running) begin
                if (step == 3'(NUM_CAND-1)) begin
                    running <= 1'b0;
                    step    <= '0;
                end else begin
                    step <= step + 3'd1;
                end
            end
            if (start || running) begin
                run_idx <= best_idx;
                run_val <= best_val;
            end
        end
    end

endmodule

// File: rtl/subpel_search_ctrl.sv
// Row sequencer for the horizontal sub-pel SAD datapath: fetches row pairs,
// accumulates five candidate SADs over the block and picks the best one.
module subpel_search_ctrl
    import subpel_search_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int MAX_ROWS = 8,
    parameter int ACC_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        rows,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    input  logic [63:0]       rd_filter,
    input  logic [63:0]       rd_ref,
    output logic [63:0]       sad_filter_pix,
    output logic [63:0]       sad_ref_pix,
    output logic              sad_input_ready,
    input  logic [60:0]       sad_in,
    output logic              done,
    output logic [2:0]        best_idx,
    output logic [ACC_W-1:0]  best_sad
);

    localparam int ROW_W = $clog2(MAX_ROWS + 1);

    state_t                         state, state_nx;
    logic [ADDR_W-1:0]              base_r;
    logic [ROW_W-1:0]               rows_r;
    logic [ROW_W-1:0]               row_r;
    logic [ROW_W-1:0]               rows_eff;
    logic [NUM_CAND-1:0][ACC_W-1:0] acc;
    logic                           last_row;
    logic                           cmp_start;
    logic                           arg_done;
    logic [2:0]                     arg_idx;
    logic [ACC_W-1:0]               arg_val;
    logic                           sad_in_unused;

    assign sad_in_unused = sad_in[60];

    always_comb begin
        if (rows == '0 || 32'(rows) > 32'(MAX_ROWS)) begin
            rows_eff = ROW_W'(MAX_ROWS);
        end else begin
            rows_eff = ROW_W'(rows);
        end
    end

    assign last_row = (row_r == rows_r - ROW_W'(1));

    always_comb begin
        state_nx        = state;
        busy            = (state != ST_IDLE);
        rd_req          = 1'b0;
        sad_input_ready = 1'b0;
        done            = 1'b0;
        rd_addr         = base_r + ADDR_W'(row_r);
        case (state)
            ST_IDLE: if (start) state_nx = ST_REQ;
            ST_REQ: begin
                rd_req   = 1'b1;
                state_nx = ST_WAIT;
            end
            ST_WAIT: if (rd_valid) state_nx = ST_ACC;
            ST_ACC: begin
                sad_input_ready = 1'b1;
                state_nx        = last_row ? ST_CMP : ST_REQ;
            end
            ST_CMP: if (arg_done) state_nx = ST_DONE;
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            base_r         <= '0;
            rows_r         <= '0;
            row_r          <= '0;
            acc            <= '0;
            cmp_start      <= 1'b0;
            sad_filter_pix <= '0;
            sad_ref_pix    <= '0;
            best_idx       <= '0;
            best_sad       <= '0;
        end else begin
            state     <= state_nx;
            // Compare starts one cycle after the last ACC so it sees the final sums.
            cmp_start <= (state == ST_ACC) && last_row;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rows_r <= rows_eff;
                        base_r <= base_addr;
                        row_r  <= '0;
                        acc    <= '0;
                    end
                end
                ST_WAIT: begin
                    if (rd_valid) begin
                        sad_filter_pix <= rd_filter;
                        sad_ref_pix    <= rd_ref;
                    end
                end
                ST_ACC: begin
                    for (int unsigned k = 0; k < NUM_CAND; k++) begin
                        acc[k] <= acc[k] + ACC_W'(sad_in[k*SAD_W +: SAD_W]);
                    end
                    row_r <= row_r + ROW_W'(1);
                end
                ST_CMP: begin
                    if (arg_done) begin
                        best_idx <= arg_idx;
                        best_sad <= arg_val;
                    end
                end
                default: ;
            endcase
        end
    end

    sad_argmin5 #(
        .ACC_W (ACC_W)
    ) u_argmin (
        .clk      (clk),
        .rst      (rst),
        .start    (cmp_start),
        .acc      (acc),
        .order    (CMP_ORDER),
        .done     (arg_done),
        .best_idx (arg_idx),
        .best_val (arg_val)
    );

endmodule

// File: tb/tb_subpel_search_ctrl.sv
// Directed bench for subpel_search_ctrl with a timing/result model of the
// block and a stub datapath (per-candidate SAD = filter XOR ref fields).
module tb_subpel_search_ctrl;

    localparam int ADDR_W   = 8;
    localparam int MAX_ROWS = 8;
    localparam int ACC_W    = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [3:0]        rows = '0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              busy, rd_req, sad_input_ready, done;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid = 1'b0;
    logic [63:0]       rd_filter = '0, rd_ref = '0;
    logic [63:0]       sad_filter_pix, sad_ref_pix;
    logic [60:0]       sad_in;
    logic [2:0]        best_idx;
    logic [ACC_W-1:0]  best_sad;

    always #5 clk = ~clk;

    assign sad_in = sad_filter_pix[60:0] ^ sad_ref_pix[60:0];

    subpel_search_ctrl #(
        .ADDR_W   (ADDR_W),
        .MAX_ROWS (MAX_ROWS),
        .ACC_W    (ACC_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .rows            (rows),
        .base_addr       (base_addr),
        .busy            (busy),
        .rd_req          (rd_req),
        .rd_addr         (rd_addr),
        .rd_valid        (rd_valid),
        .rd_filter       (rd_filter),
        .rd_ref          (rd_ref),
        .sad_filter_pix  (sad_filter_pix),
        .sad_ref_pix     (sad_ref_pix),
        .sad_input_ready (sad_input_ready),
        .sad_in          (sad_in),
        .done            (done),
        .best_idx        (best_idx),
        .best_sad        (best_sad)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state
    logic [63:0] mem_f [256];
    logic [63:0] mem_r [256];
    bit          chk_en = 1'b0;
    bit          blk_active = 1'b0;
    bit          spur_req = 1'b0, spur_cmp = 1'b0;
    int          blk_rows = 1, blk_L = 1, start_cyc = 0;
    logic [7:0]  blk_base = '0;
    logic [2:0]  new_idx = '0, cur_idx = '0;
    logic [15:0] new_sad = '0, cur_sad = '0;
    int          req_cnt = 0, sir_cnt = 0, done_rel = -1;

    function automatic logic [63:0] pack5(input int rh, input int rq, input int f,
                                          input int lq, input int lh);
        return {4'h0, 12'(lh), 12'(lq), 12'(f), 12'(rq), 12'(rh)};
    endfunction

    // Sum each candidate over the block rows, then pick the minimum in
    // priority order F, RQ, LQ, RH, LH with ties kept by the earlier entry.
    task automatic predict();
        int          s [5];
        int          pr [5];
        int          best;
        logic [63:0] x;
        logic [7:0]  a;
        pr = '{2, 1, 3, 0, 4};
        for (int k = 0; k < 5; k++) s[k] = 0;
        for (int i = 0; i < blk_rows; i++) begin
            a = 8'(blk_base + 8'(i));
            x = mem_f[a] ^ mem_r[a];
            for (int k = 0; k < 5; k++) s[k] += int'(x[12*k +: 12]);
        end
        best = pr[0];
        for (int j = 1; j < 5; j++) if (s[pr[j]] < s[best]) best = pr[j];
        new_idx = 3'(best);
        new_sad = 16'(s[best]);
    endtask

    // Per-cycle compare, sampled 1 time unit after each rising edge
    int         rel, per, nrow_cyc, dcyc;
    bit         exp_req, exp_sir;
    logic [7:0] ea;
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (chk_en) begin
            if (blk_active) begin
                rel      = cyc - start_cyc;
                per      = blk_L + 2;
                nrow_cyc = blk_rows * per;
                dcyc     = nrow_cyc + 6;
                if (rel == dcyc) begin
                    cur_idx = new_idx;
                    cur_sad = new_sad;
                end
                exp_req = (rel <= nrow_cyc) && ((rel - 1) % per == 0);
                exp_sir = (rel <= nrow_cyc) && (rel % per == 0);
                if (rd_req) req_cnt++;
                if (sad_input_ready) sir_cnt++;
                if (done) done_rel = rel;
                chk("busy", busy, 1);
                chk("rd_req", rd_req, exp_req);
                chk("sad_input_ready", sad_input_ready, exp_sir);
                chk("done", done, rel == dcyc);
                chk("best_idx", best_idx, cur_idx);
                chk("best_sad", best_sad, cur_sad);
                if (exp_req) chk("rd_addr", rd_addr, 8'(blk_base + 8'((rel - 1) / per)));
                if (exp_sir) begin
                    ea = 8'(blk_base + 8'(rel / per - 1));
                    chk("filter_pix", sad_filter_pix, mem_f[ea]);
                    chk("ref_pix", sad_ref_pix, mem_r[ea]);
                end
                if (rel == dcyc) blk_active = 1'b0;
            end else begin
                chk("idle_busy", busy, 0);
                chk("idle_rd_req", rd_req, 0);
                chk("idle_sir", sad_input_ready, 0);
                chk("idle_done", done, 0);
                chk("idle_best_idx", best_idx, cur_idx);
                chk("idle_best_sad", best_sad, cur_sad);
            end
        end
    end

    // Row-buffer responder: one response blk_L cycles after each rd_req,
    // plus optional spurious beats carrying junk data.
    bit         pend = 1'b0;
    int         pcnt = 0;
    logic [7:0] paddr = '0;
    always @(negedge clk) begin
        rd_valid  = 1'b0;
        rd_filter = 64'hA5A5_5A5A_C3C3_3C3C;
        rd_ref    = 64'h0F0F_F0F0_1234_5678;
        if (pend) begin
            pcnt--;
            if (pcnt == 0) begin
                rd_valid  = 1'b1;
                rd_filter = mem_f[paddr];
                rd_ref    = mem_r[paddr];
                pend      = 1'b0;
            end
        end
        if (rd_req) begin
            pend  = 1'b1;
            pcnt  = blk_L;
            paddr = rd_addr;
            if (spur_req) rd_valid = 1'b1;
        end
        if (spur_cmp && blk_active && (cyc - start_cyc) == blk_rows * (blk_L + 2) + 2)
            rd_valid = 1'b1;
    end

    task automatic run_block(input int r_in, input logic [7:0] base, input int lat,
                             input bit sp_r, input bit sp_c, input bit poke);
        @(negedge clk);
        blk_rows  = (r_in == 0 || r_in > MAX_ROWS) ? MAX_ROWS : r_in;
        blk_base  = base;
        blk_L     = lat;
        spur_req  = sp_r;
        spur_cmp  = sp_c;
        predict();
        req_cnt   = 0;
        sir_cnt   = 0;
        done_rel  = -1;
        rows      = 4'(r_in);
        base_addr = base;
        start     = 1'b1;
        start_cyc = cyc;
        blk_active = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        rows      = 4'd3;
        base_addr = 8'hEE;
        while (cyc - start_cyc < blk_rows * (lat + 2) + 6) begin
            @(negedge clk);
            start = poke && (cyc - start_cyc == 5);
        end
        start    = 1'b0;
        spur_req = 1'b0;
        spur_cmp = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_f[i] = '0;
            mem_r[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_done", done, 0);
        chk("rst_filter_pix", sad_filter_pix, 0);
        chk("rst_best_idx", best_idx, 0);
        chk("rst_best_sad", best_sad, 0);
        rst    = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Equal rows: zero SADs, tie across all five resolves to F
        for (int i = 0; i < 4; i++) begin
            mem_f[8'h10 + i] = {8{8'h40}};
            mem_r[8'h10 + i] = {8{8'h40}};
        end
        run_block(4, 8'h10, 1, 0, 0, 0);
        chk("eq_best_idx", best_idx, 2);
        chk("eq_best_sad", best_sad, 0);
        chk("eq_done_cycle", done_rel, 18);

        // Stubbed SADs with bit 60 set (ignored), plus a start while busy
        for (int i = 0; i < 3; i++) begin
            mem_f[8'h20 + i] = pack5(60, 20, 40, 30, 50) | (64'd1 << 60);
            mem_r[8'h20 + i] = '0;
        end
        run_block(3, 8'h20, 1, 0, 0, 1);
        chk("stub_best_idx", best_idx, 1);
        chk("stub_best_sad", best_sad, 60);

        // Ties (back-to-back starts, each in the cycle after done)
        for (int i = 0; i < 2; i++) mem_f[8'h30 + i] = pack5(100, 10, 11, 10, 100);
        run_block(2, 8'h30, 1, 0, 0, 0);
        chk("tie_rq_lq_idx", best_idx, 1);
        chk("tie_rq_lq_sad", best_sad, 20);
        for (int i = 0; i < 2; i++) mem_f[8'h38 + i] = pack5(7, 7, 7, 7, 7);
        run_block(2, 8'h38, 1, 0, 0, 0);
        chk("tie_all_idx", best_idx, 2);
        chk("tie_all_sad", best_sad, 14);

        // rows=0 -> 8 rows, address wraps 0xFC..0x03
        for (int i = 0; i < 8; i++) begin
            mem_f[8'(8'hFC + 8'(i))] = pack5(50 + i, 40 + 2 * i, 45, 60 - i, 70);
            mem_r[8'(8'hFC + 8'(i))] = 64'h0;
        end
        mem_f[8'h04] = pack5(4000, 4000, 4000, 4000, 0);
        run_block(0, 8'hFC, 1, 0, 0, 0);
        chk("rows0_req_cnt", req_cnt, 8);
        chk("rows0_sir_cnt", sir_cnt, 8);
        chk("rows0_best_idx", best_idx, 2);
        chk("rows0_best_sad", best_sad, 360);

        // rows=12 clamps to 8
        for (int i = 0; i < 12; i++) mem_f[8'h40 + i] = pack5(30, 30, 30, 30, 5 + i);
        run_block(12, 8'h40, 1, 0, 0, 0);
        chk("rows12_req_cnt", req_cnt, 8);
        chk("rows12_best_idx", best_idx, 4);
        chk("rows12_best_sad", best_sad, 68);

        // Slow memory with spurious rd_valid in REQ and CMP
        for (int i = 0; i < 2; i++) mem_f[8'h50 + i] = pack5(60, 20, 40, 30, 50);
        run_block(2, 8'h50, 4, 1, 1, 0);
        chk("slow_done_cycle", done_rel, 18);
        chk("slow_req_cnt", req_cnt, 2);
        chk("slow_sir_cnt", sir_cnt, 2);
        chk("slow_best_idx", best_idx, 1);
        chk("slow_best_sad", best_sad, 40);

        // Reset in WAIT, stale rd_valid one cycle later
        for (int i = 0; i < 4; i++) mem_f[8'h60 + i] = pack5(9, 8, 7, 6, 5);
        @(negedge clk);
        blk_rows   = 4;
        blk_base   = 8'h60;
        blk_L      = 2;
        predict();
        rows       = 4'd4;
        base_addr  = 8'h60;
        start      = 1'b1;
        start_cyc  = cyc;
        blk_active = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst        = 1'b1;
        blk_active = 1'b0;
        cur_idx    = '0;
        cur_sad    = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_rd_addr", rd_addr, 0);
        chk("rstmid_filter_pix", sad_filter_pix, 0);
        chk("rstmid_ref_pix", sad_ref_pix, 0);
        repeat (3) @(negedge clk);
        chk("rstmid_stale_pix", sad_filter_pix, 0);
        run_block(2, 8'h60, 1, 0, 0, 0);
        chk("after_rst_best_idx", best_idx, 4);
        chk("after_rst_best_sad", best_sad, 10);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
